// File: rtl/mmacc_pkg.sv
// Shared constants and helpers for the matrix-multiply accumulator datapath.
// The systolic array controller also uses lane_delay() to count drain cycles.
package mmacc_pkg;

    localparam int MODE_SKEW     = 0;
    localparam int MODE_DESKEW   = 1;
    localparam int OPERAND_WIDTH = 10;
    localparam int MAX_LANES     = 16;

    // Skew delays lane i by i+1 stages; de-skew delays it by lanes-i stages.
    function automatic int lane_delay(input int lane, input int lanes, input int mode);
        return (mode == MODE_DESKEW) ? (lanes - lane) : (lane + 1);
    endfunction

endpackage

// File: rtl/skew_register_bank_if.sv
// Operand vector bus between the upstream sequencer and the skew register bank.
interface skew_register_bank_if
    import mmacc_pkg::*;
#(
    parameter int WIDTH = OPERAND_WIDTH,
    parameter int LANES = 4
);

    logic                   en;
    logic                   sclr;
    logic                   in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic [LANES-1:0]       out_valid;
    logic [LANES*WIDTH-1:0] out_data;

    modport master (
        output en, sclr, in_valid, in_data,
        input  out_valid, out_data
    );

    modport slave (
        input  en, sclr, in_valid, in_data,
        output out_valid, out_data
    );

endinterface

// File: rtl/skew_register_bank_delay_line.sv
// Fixed-depth register pipeline for one lane, with flush, stall and zero-fill.
module delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             sclr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;

    // NOTE: every stage is a flop with its own async clear; this is a shift
    // chain rather than a RAM, so resetting all of it is cheap and keeps
    // bubbles at zero from the first cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (sclr) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (en) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_valid ? in_data : '0;
            // NOTE: non-blocking here is what makes the loop a shift; with
            // blocking assignments every stage would collapse onto stage 0.
            for (int s = 1; s < DEPTH; s++) begin
                valid_q[s] <= valid_q[s-1];
                data_q[s]  <= data_q[s-1];
            end
        end
    end

    // Zero-fill on entry keeps data at 0 wherever valid is 0, so no output mask is needed.
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/skew_register_bank.sv
// Multi-lane operand register bank: skews vectors into the systolic array
// (MODE_SKEW) or realigns results leaving it (MODE_DESKEW).
module skew_register_bank
    import mmacc_pkg::*;
#(
    parameter int WIDTH = OPERAND_WIDTH,
    parameter int LANES = 4,
    parameter int MODE  = MODE_SKEW
) (
    input logic                 clk,
    input logic                 clr,
    skew_register_bank_if.slave bus
);

    logic [LANES-1:0]            lane_valid;
    logic [LANES-1:0][WIDTH-1:0] lane_data;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int DEPTH = lane_delay(i, LANES, MODE);

        delay_line #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) u_line (
            .clk       (clk),
            .clr       (clr),
            .en        (bus.en),
            .sclr      (bus.sclr),
            .in_valid  (bus.in_valid),
            .in_data   (bus.in_data[i*WIDTH +: WIDTH]),
            .out_valid (lane_valid[i]),
            .out_data  (lane_data[i])
        );
    end

    assign bus.out_valid = lane_valid;
    assign bus.out_data  = lane_data;

endmodule

// File: tb/tb_skew_register_bank.sv
// Directed bench for skew_register_bank: skew, de-skew, single-lane and 16-bit
// instances run the same stimulus against hand-computed expectations.
module tb_skew_register_bank;
    import mmacc_pkg::*;

    typedef struct {
        logic        en;
        logic        sclr;
        logic        in_valid;
        logic [39:0] data;
        logic [3:0]  v0;
        logic [39:0] d0;
        logic [3:0]  v1;
        logic [39:0] d1;
    } vec_t;

    logic clk;
    logic clr;
    int   checks;
    int   failures;
    vec_t tbl[$];

    skew_register_bank_if #(.WIDTH(10), .LANES(4)) b_skew ();
    skew_register_bank_if #(.WIDTH(10), .LANES(4)) b_deskew ();
    skew_register_bank_if #(.WIDTH(10), .LANES(1)) b_one0 ();
    skew_register_bank_if #(.WIDTH(10), .LANES(1)) b_one1 ();
    skew_register_bank_if #(.WIDTH(16), .LANES(4)) b_wide ();

    skew_register_bank #(.WIDTH(10), .LANES(4), .MODE(MODE_SKEW)) u_skew (
        .clk(clk), .clr(clr), .bus(b_skew.slave));
    skew_register_bank #(.WIDTH(10), .LANES(4), .MODE(MODE_DESKEW)) u_deskew (
        .clk(clk), .clr(clr), .bus(b_deskew.slave));
    skew_register_bank #(.WIDTH(10), .LANES(1), .MODE(MODE_SKEW)) u_one0 (
        .clk(clk), .clr(clr), .bus(b_one0.slave));
    skew_register_bank #(.WIDTH(10), .LANES(1), .MODE(MODE_DESKEW)) u_one1 (
        .clk(clk), .clr(clr), .bus(b_one1.slave));
    skew_register_bank #(.WIDTH(16), .LANES(4), .MODE(MODE_SKEW)) u_wide (
        .clk(clk), .clr(clr), .bus(b_wide.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] lv(input int a3, input int a2, input int a1, input int a0);
        return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    endfunction

    function automatic logic [63:0] widen(input logic [39:0] d);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[i*16 +: 16] = {6'b0, d[i*10 +: 10]};
        return w;
    endfunction

    function automatic vec_t mk(input logic en, input logic sclr, input logic iv,
                                input logic [39:0] data,
                                input logic [3:0] v0, input logic [39:0] d0,
                                input logic [3:0] v1, input logic [39:0] d1);
        vec_t v;
        v.en = en; v.sclr = sclr; v.in_valid = iv; v.data = data;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // v0/d0: skew expectation (also single-lane and wide); v1/d1: de-skew expectation.
    task automatic check_all(input string tag, input logic [3:0] v0, input logic [39:0] d0,
                             input logic [3:0] v1, input logic [39:0] d1);
        logic [39:0] d0_copy;
        d0_copy = d0;
        check({tag, " skew_valid"},   64'(b_skew.out_valid),   64'(v0));
        check({tag, " skew_data"},    64'(b_skew.out_data),    64'(d0));
        check({tag, " deskew_valid"}, 64'(b_deskew.out_valid), 64'(v1));
        check({tag, " deskew_data"},  64'(b_deskew.out_data),  64'(d1));
        check({tag, " one0_valid"},   64'(b_one0.out_valid),   64'(v0[0]));
        check({tag, " one0_data"},    64'(b_one0.out_data),    64'(d0_copy[9:0]));
        check({tag, " one1_valid"},   64'(b_one1.out_valid),   64'(v0[0]));
        check({tag, " one1_data"},    64'(b_one1.out_data),    64'(d0_copy[9:0]));
        check({tag, " wide_valid"},   64'(b_wide.out_valid),   64'(v0));
        check({tag, " wide_data"},    b_wide.out_data,         widen(d0));
    endtask

    task automatic check_zero(input string tag);
        check_all(tag, 4'b0, 40'b0, 4'b0, 40'b0);
    endtask

    task automatic drive(input logic en, input logic sclr, input logic iv, input logic [39:0] data);
        b_skew.en = en;   b_skew.sclr = sclr;   b_skew.in_valid = iv;   b_skew.in_data = data;
        b_deskew.en = en; b_deskew.sclr = sclr; b_deskew.in_valid = iv; b_deskew.in_data = data;
        b_one0.en = en;   b_one0.sclr = sclr;   b_one0.in_valid = iv;   b_one0.in_data = data[9:0];
        b_one1.en = en;   b_one1.sclr = sclr;   b_one1.in_valid = iv;   b_one1.in_data = data[9:0];
        b_wide.en = en;   b_wide.sclr = sclr;   b_wide.in_valid = iv;   b_wide.in_data = widen(data);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [39:0] junk;
        logic [39:0] stall_data;
        checks   = 0;
        failures = 0;
        junk       = lv(9, 9, 9, 9);
        stall_data = lv(7, 7, 7, 7);

        // Single vector: skew and de-skew timing.
        tbl.push_back(mk(1, 0, 1, lv(4, 3, 2, 1), 4'b0001, lv(0, 0, 0, 1), 4'b1000, lv(4, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b0010, lv(0, 0, 2, 0), 4'b0100, lv(0, 3, 0, 0)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b0100, lv(0, 3, 0, 0), 4'b0010, lv(0, 0, 2, 0)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b1000, lv(4, 0, 0, 0), 4'b0001, lv(0, 0, 0, 1)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b0000, '0,             4'b0000, '0));
        // Same vector with a two-edge stall; the valid data offered during the stall is dropped.
        tbl.push_back(mk(1, 0, 1, lv(4, 3, 2, 1), 4'b0001, lv(0, 0, 0, 1), 4'b1000, lv(4, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 1, stall_data,     4'b0001, lv(0, 0, 0, 1), 4'b1000, lv(4, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 1, stall_data,     4'b0001, lv(0, 0, 0, 1), 4'b1000, lv(4, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b0010, lv(0, 0, 2, 0), 4'b0100, lv(0, 3, 0, 0)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b0100, lv(0, 3, 0, 0), 4'b0010, lv(0, 0, 2, 0)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b1000, lv(4, 0, 0, 0), 4'b0001, lv(0, 0, 0, 1)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b0000, '0,             4'b0000, '0));
        // Streaming with bubbles: valid pattern 1,1,0,1,1,1,0,1, vector k carries k on every lane.
        tbl.push_back(mk(1, 0, 1, lv(1, 1, 1, 1), 4'b0001, lv(0, 0, 0, 1), 4'b1000, lv(1, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 1, lv(2, 2, 2, 2), 4'b0011, lv(0, 0, 1, 2), 4'b1100, lv(2, 1, 0, 0)));
        tbl.push_back(mk(1, 0, 0, lv(3, 3, 3, 3), 4'b0110, lv(0, 1, 2, 0), 4'b0110, lv(0, 2, 1, 0)));
        tbl.push_back(mk(1, 0, 1, lv(4, 4, 4, 4), 4'b1101, lv(1, 2, 0, 4), 4'b1011, lv(4, 0, 2, 1)));
        tbl.push_back(mk(1, 0, 1, lv(5, 5, 5, 5), 4'b1011, lv(2, 0, 4, 5), 4'b1101, lv(5, 4, 0, 2)));
        tbl.push_back(mk(1, 0, 1, lv(6, 6, 6, 6), 4'b0111, lv(0, 4, 5, 6), 4'b1110, lv(6, 5, 4, 0)));
        tbl.push_back(mk(1, 0, 0, lv(7, 7, 7, 7), 4'b1110, lv(4, 5, 6, 0), 4'b0111, lv(0, 6, 5, 4)));
        tbl.push_back(mk(1, 0, 1, lv(8, 8, 8, 8), 4'b1101, lv(5, 6, 0, 8), 4'b1011, lv(8, 0, 6, 5)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b1010, lv(6, 0, 8, 0), 4'b0101, lv(0, 8, 0, 6)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b0100, lv(0, 8, 0, 0), 4'b0010, lv(0, 0, 8, 0)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b1000, lv(8, 0, 0, 0), 4'b0001, lv(0, 0, 0, 8)));
        tbl.push_back(mk(1, 0, 0, junk,           4'b0000, '0,             4'b0000, '0));

        // Power-on reset, then an ordinary edge after release.
        clr = 1'b0;
        drive(1, 0, 1, lv(5, 5, 5, 5));
        step();
        step();
        check_zero("reset_hold");
        clr = 1'b1;
        drive(1, 0, 0, junk);
        step();
        check_zero("reset_release");

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].en, tbl[r].sclr, tbl[r].in_valid, tbl[r].data);
            step();
            check_all($sformatf("row%0d", r), tbl[r].v0, tbl[r].d0, tbl[r].v1, tbl[r].d1);
        end

        // Flush with en=0, then with en=1 and a valid vector offered on the flush edge.
        for (int pass = 0; pass < 2; pass++) begin
            drive(1, 0, 1, lv(40, 30, 20, 10));
            step();
            drive(1, 0, 1, lv(41, 31, 21, 11));
            step();
            check_all($sformatf("flush%0d_pre", pass),
                      4'b0011, lv(0, 0, 20, 11), 4'b1100, lv(41, 30, 0, 0));
            drive(logic'(pass), 1, 1, lv(5, 5, 5, 5));
            step();
            check_zero($sformatf("flush%0d_edge", pass));
            for (int k = 0; k < 4; k++) begin
                drive(1, 0, 0, junk);
                step();
                check_zero($sformatf("flush%0d_drain%0d", pass, k));
            end
        end

        // Asynchronous clear mid-cycle with every stage loaded.
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, lv(4, 3, 2, 1));
            step();
        end
        check_all("preload", 4'b1111, lv(4, 3, 2, 1), 4'b1111, lv(4, 3, 2, 1));
        #2;
        clr = 1'b0;
        #1;
        check_zero("async_clr");
        step();
        check_zero("clr_held_edge");
        drive(1, 0, 0, junk);
        #3;
        clr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_zero($sformatf("post_clr%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
